mem_read_port: RTL and testbench

MEM_READ_PORT -- requirements
Module: mem_read_port

---
 rtl/mem_read_port_pkg.sv | 13 +
 rtl/mem_read_fifo.sv | 61 ++++++
 rtl/mem_read_port.sv | 102 ++++++++++
 tb/tb_mem_read_port.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_port_pkg.sv
// Shared constants and width helpers for the memory read port.
package mem_read_port_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int INFLIGHT_W     = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_read_fifo.sv
// Output buffer: power-of-two ring with occupancy count and synchronous flush.
module mem_read_fifo
  import mem_read_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         data_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_C);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/mem_read_port.sv
// Credit-based read port: sync RAM reads into an output FIFO.
// Define MEM_READ_PORT_RDATA_REG_EN to register mem_rdata (3-cycle latency).
module mem_read_port
  import mem_read_port_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic              addr_done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [CW-1:0]         count;
  logic                  empty, full;
  logic                  hs, pop, push;
  logic [DATA_W-1:0]     push_data;
  logic [INFLIGHT_W-1:0] inflight;
  logic [CW:0]           used;
  logic                  v1_q, v1_d;
  logic                  done_q, done_d;

  assign used       = (CW+1)'(count) + (CW+1)'(inflight);
  assign addr_ready = !run && (used < DEPTH_L) && !full;
  assign hs         = addr_valid && addr_ready;
  assign mem_en     = hs;
  assign mem_addr   = addr;
  assign pop        = out_valid && out_ready && !run;
  assign out_valid  = !empty;
  assign done       = done_q;
  assign v1_d       = hs;

`ifdef MEM_READ_PORT_RDATA_REG_EN
  logic              v2_q, v2_d;
  logic [DATA_W-1:0] d2_q;

  assign v2_d      = v1_q && !run;
  assign inflight  = INFLIGHT_W'(v1_q) + INFLIGHT_W'(v2_q);
  assign push      = v2_q;
  assign push_data = d2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q <= 1'b0;
      d2_q <= '0;
    end else begin
      v2_q <= v2_d;
      if (v1_q) d2_q <= mem_rdata;
    end
  end
`else
  assign inflight  = INFLIGHT_W'(v1_q);
  assign push      = v1_q;
  assign push_data = mem_rdata;
`endif

  // run wins: flush drops the buffer and any read landing this cycle
  assign done_d = !run &&
    (done_q || (addr_done && inflight == '0 && empty));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      done_q <= done_d;
    end
  end

  mem_read_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (run),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (out_data),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_mem_read_port.sv
// Scoreboard bench for mem_read_port with a synchronous RAM model.
module tb_mem_read_port;

`ifdef MEM_READ_PORT_RDATA_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        addr_valid = 1'b0;
  logic        addr_ready;
  logic [9:0]  addr = '0;
  logic        addr_done = 1'b0;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        done;

  logic [31:0] ram [0:1023];
  logic [31:0] q [$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int cyc_n = 0;
  int last_pop_cyc = 0;
  int over_cnt = 0;

  always #5 clk = ~clk;

  mem_read_port dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .addr_done  (addr_done),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .done       (done)
  );

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // issue side: every accepted address predicts its RAM word
  always @(negedge clk) begin
    if (!rst && !run && addr_valid && addr_ready)
      q.push_back(ram[addr]);
  end

  // monitor side: compare each delivered word in order
  always @(negedge clk) begin
    if (rst || run) begin
      q.delete();
    end else begin
      if (int'(dut.u_fifo.count_o) > DEPTH) over_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        last_pop_cyc = cyc_n;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %h expected none", out_data);
        end else if (out_data !== q[0]) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", out_data, q[0]);
          void'(q.pop_front());
        end else begin
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic do_run;
    run = 1'b1;
    @(negedge clk);
    cyc();
    run = 1'b0;
  endtask

  task automatic stream(input int n, input int base, input int mode,
                        input int maxc, input bit set_done);
    int idx = 0;
    int c = 0;
    while ((idx < n || q.size() != 0) && c < maxc) begin
      addr_valid = (idx < n);
      addr = 10'(base + idx);
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      if (addr_valid && addr_ready) idx++;
      c++;
      cyc();
      addr_valid = 1'b0;
      if (idx == n && set_done) addr_done = 1'b1;
    end
    chk("stream_timeout", 32'(c < maxc), 32'd1);
  endtask

  task automatic accept_n(input int n, input int base, output int got);
    int c = 0;
    got = 0;
    while (got < n && c < 20) begin
      addr_valid = 1'b1;
      addr = 10'(base + got);
      @(negedge clk); #1;
      if (addr_valid && addr_ready) got++;
      c++;
      cyc();
    end
    addr_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idx, p0, dc, got, bad;
    bit seen;
    for (int a = 0; a < 1024; a++) ram[a] = 32'(a);
    ram[5] = 32'hA5A5_A5A5;
    for (int a = 100; a < 200; a++) ram[a] = 32'h1000_0000 + 32'(a);
    for (int a = 200; a < 204; a++) ram[a] = 32'hD000_0000 + 32'(a);
    ram[300] = 32'hBAD0_0300;
    ram[301] = 32'hBAD0_0301;
    ram[310] = 32'h600D_0310;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // single read and latency
    do_run();
    addr_valid = 1'b1;
    addr = 10'd5;
    out_ready = 1'b1;
    @(negedge clk);
    chk("single_hs", 32'(addr_ready && mem_en), 32'd1);
    cyc();
    addr_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk($sformatf("single_valid_t%0d", k), 32'(out_valid),
          32'(k == LAT));
      if (k == LAT) chk("single_data", out_data, 32'hA5A5_A5A5);
      cyc();
    end

    // back-pressure: credit stops at the buffer depth
    ram[5] = 32'd5;
    do_run();
    p0 = pops;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      addr_valid = 1'b1;
      addr = 10'(idx);
      @(negedge clk); #1;
      if (addr_ready) idx++;
      if (c == 5) chk("bp_ready_low", 32'(addr_ready), 32'd0);
      cyc();
    end
    addr_valid = 1'b0;
    chk("bp_accepts", 32'(idx), 32'd2);
    stream(6, 2, 0, 80, 1'b0);
    chk("bp_pops", 32'(pops - p0), 32'd8);

    // random stalls over 100 addresses
    do_run();
    p0 = pops;
    over_cnt = 0;
    stream(100, 100, 1, 3000, 1'b0);
    chk("rand_pops", 32'(pops - p0), 32'd100);
    chk("rand_count_bound", 32'(over_cnt), 32'd0);

    // done timing and hold
    do_run();
    stream(4, 200, 0, 60, 1'b1);
    seen = 1'b0;
    dc = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dc = cyc_n;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_rise_delay", 32'(dc - last_pop_cyc), 32'd2);
    cyc();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!done) bad++;
      cyc();
    end
    chk("done_hold", 32'(bad), 32'd0);
    addr_done = 1'b0;
    do_run();
    @(negedge clk);
    chk("done_clr_run", 32'(done), 32'd0);
    cyc();

    // run while data is buffered and in flight
    out_ready = 1'b0;
    accept_n(2, 300, got);
    chk("mid_accepts", 32'(got), 32'd2);
    do_run();
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    cyc();
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) bad++;
      cyc();
    end
    chk("mid_no_stale", 32'(bad), 32'd0);
    p0 = pops;
    stream(1, 310, 0, 20, 1'b0);
    chk("mid_new_pops", 32'(pops - p0), 32'd1);

    // async reset between edges
    do_run();
    stream(1, 400, 0, 20, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    cyc();
    addr_done = 1'b0;
    out_ready = 1'b0;
    accept_n(2, 410, got);
    cyc();
    cyc();
    @(negedge clk);
    chk("pre_rst_state", {30'd0, out_valid, done}, 32'd3);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    cyc();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (out_valid) bad++;
      cyc();
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);
    p0 = pops;
    stream(2, 420, 0, 30, 1'b0);
    chk("post_rst_pops", 32'(pops - p0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
